// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter.
//   arb_state_e  : arbiter FSM states
//   WMODE_*      : memory write_mode encodings (00 read, 01 byte, 10 half, 11 word)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_READ    = 2'b01,
    ST_WRITE   = 2'b10,
    ST_RECOVER = 2'b11
  } arb_state_e;

  localparam logic [1:0] WMODE_NONE = 2'b00;
  localparam logic [1:0] WMODE_BYTE = 2'b01;
  localparam logic [1:0] WMODE_HALF = 2'b10;
  localparam logic [1:0] WMODE_WORD = 2'b11;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational grant selection for the two-port memory arbiter.
//   req_i[1:0]    in  per-port request
//   last_grant_i  in  port granted most recently (round-robin build only)
//   grant_o       out winning port index
//   valid_o       out at least one request present
// Build option: MEM_ARB_RR_EN selects round-robin on conflict; when undefined,
// port 0 has fixed priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       grant_o,
  output logic       valid_o
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    valid_o = |req_i;
    // On conflict the port that did not win last time goes next.
    if (&req_i) grant_o = ~last_grant_i;
    else        grant_o = ~req_i[0];
  end
`else
  always_comb begin
    valid_o = |req_i;
    grant_o = ~req_i[0];
  end

  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one byte-addressable memory port between the CPU
// sequencer (port 0) and the debug/dump engine (port 1).
//   clk, rst             clock, asynchronous active-low reset
//   req[1:0]             level requests, held until ack
//   wmode0/1, addr0/1, wdata0/1  per-port access mode, byte address, write data
//   ack[1:0], err        one-cycle completion pulse per port, write error flag
//   rdata                read word, valid from ack until next grant
//   busy                 high whenever not IDLE
//   mem_address, mem_write_mode, mem_wbyte/whalf/wword  memory side controls
//   mem_rdata, mem_done, mem_error                      memory side status
// Build option: MEM_ARB_RR_EN (round-robin arbitration, see mem_arb_pick).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned READ_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [1:0]        wmode0,
  input  logic [1:0]        wmode1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        ack,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic [1:0]        mem_write_mode,
  output logic [7:0]        mem_wbyte,
  output logic [15:0]       mem_whalf,
  output logic [DATA_W-1:0] mem_wword,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  input  logic              mem_error
);

  localparam int unsigned CNT_W = $clog2(READ_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(READ_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ACK = CNT_W'(READ_LAT);

  arb_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              gnt_q;
  logic              last_grant_q;
  logic [1:0]        ack_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        wmode_q;
  logic [DATA_W-1:0] wdata_q;

  logic              pick_grant;
  logic              pick_valid;
  logic [ADDR_W-1:0] sel_addr;
  logic [1:0]        sel_wmode;
  logic [DATA_W-1:0] sel_wdata;

  mem_arb_pick u_pick (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .grant_o      (pick_grant),
    .valid_o      (pick_valid)
  );

  always_comb begin
    sel_addr  = pick_grant ? addr1  : addr0;
    sel_wmode = pick_grant ? wmode1 : wmode0;
    sel_wdata = pick_grant ? wdata1 : wdata0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;
      ack_q        <= '0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      addr_q       <= '0;
      wmode_q      <= WMODE_NONE;
      wdata_q      <= '0;
    end else begin
      ack_q <= '0;
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            gnt_q        <= pick_grant;
            last_grant_q <= pick_grant;
            addr_q       <= sel_addr;
            wmode_q      <= sel_wmode;
            wdata_q      <= sel_wdata;
            cnt_q        <= '0;
            state_q      <= (sel_wmode == WMODE_NONE) ? ST_READ : ST_WRITE;
          end
        end
        ST_READ: begin
          // Data is captured at READ_LAT-1 and acknowledged one cycle later,
          // giving READ_LAT+1 cycles from grant edge to ack.
          if (cnt_q == CNT_ACK) begin
            ack_q   <= gnt_q ? 2'b10 : 2'b01;
            state_q <= ST_IDLE;
          end else begin
            if (cnt_q == CNT_CAP) rdata_q <= mem_rdata;
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_WRITE: begin
          if (mem_error || mem_done) begin
            ack_q   <= gnt_q ? 2'b10 : 2'b01;
            err_q   <= mem_error;
            wmode_q <= WMODE_NONE;
            state_q <= ST_RECOVER;
          end
        end
        ST_RECOVER: state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  assign ack            = ack_q;
  assign err            = err_q;
  assign rdata          = rdata_q;
  assign busy           = (state_q != ST_IDLE);
  assign mem_address    = addr_q;
  assign mem_write_mode = wmode_q;
  assign mem_wbyte      = wdata_q[7:0];
  assign mem_whalf      = wdata_q[15:0];
  assign mem_wword      = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed, scoreboard-checked bench for mem_port_arbiter.
// Honours MEM_ARB_RR_EN for the expected conflict grant order.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req;
  logic [1:0]  wmode0, wmode1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [1:0]  ack;
  logic        err;
  logic [31:0] rdata;
  logic        busy;
  logic [31:0] mem_address;
  logic [1:0]  mem_write_mode;
  logic [7:0]  mem_wbyte;
  logic [15:0] mem_whalf;
  logic [31:0] mem_wword;
  logic [31:0] mem_rdata;
  logic        mem_done, mem_error;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [1:0]  ack;
    logic        err;
    logic        chk_rdata;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(2)) dut (
    .clk(clk), .rst(rst), .req(req),
    .wmode0(wmode0), .wmode1(wmode1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack(ack), .err(err), .rdata(rdata), .busy(busy),
    .mem_address(mem_address), .mem_write_mode(mem_write_mode),
    .mem_wbyte(mem_wbyte), .mem_whalf(mem_whalf), .mem_wword(mem_wword),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_error(mem_error)
  );

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  assign mem_rdata = rd_model(mem_address);

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] a, input logic e, input logic c, input logic [31:0] d);
    exp_t x;
    x.ack = a; x.err = e; x.chk_rdata = c; x.rdata = d;
    sb.push_back(x);
  endtask

  // Waits (bounded) for an ack pulse, then checks it against the scoreboard head.
  task automatic wait_ack(input string tag, input int lim, output int n);
    exp_t x;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack == 2'b00 && n < lim);
    check({tag, " ack_seen"}, ack != 2'b00, 1'b1);
    if (ack != 2'b00) begin
      check({tag, " sb_nonempty"}, sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        x = sb.pop_front();
        check({tag, " ack"}, ack, x.ack);
        check({tag, " err"}, err, x.err);
        if (x.chk_rdata) check({tag, " rdata"}, rdata, x.rdata);
      end
    end
  endtask

  logic [1:0] exp_port [4];

  initial begin
    int n;
    req = 2'b00; wmode0 = 2'b00; wmode1 = 2'b00;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    mem_done = 1'b0; mem_error = 1'b0;
`ifdef MEM_ARB_RR_EN
    exp_port = '{2'd0, 2'd1, 2'd0, 2'd1};
`else
    exp_port = '{2'd0, 2'd0, 2'd0, 2'd0};
`endif

    // Reset values
    repeat (3) @(negedge clk);
    check("rst ack", ack, 2'b00);
    check("rst err", err, 1'b0);
    check("rst rdata", rdata, 32'h0);
    check("rst busy", busy, 1'b0);
    check("rst addr", mem_address, 32'h0);
    check("rst wmode", mem_write_mode, 2'b00);
    check("rst wword", mem_wword, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("idle busy", busy, 1'b0);

    // Read on port 0
    addr0 = 32'h100; wmode0 = 2'b00; req = 2'b01;
    push(2'b01, 1'b0, 1'b1, 32'hDEADBEEF);
    @(negedge clk);
    check("rd busy", busy, 1'b1);
    check("rd addr", mem_address, 32'h100);
    check("rd wmode", mem_write_mode, 2'b00);
    wait_ack("rd", 8, n);
    req = 2'b00;
    check("rd latency", n, 3);
    @(negedge clk);
    check("rd ack pulse", ack, 2'b00);
    check("rd rdata hold", rdata, 32'hDEADBEEF);
    check("rd idle busy", busy, 1'b0);
    check("rd addr hold", mem_address, 32'h100);

    // Byte write on port 1, done after 4 cycles
    addr1 = 32'h40; wmode1 = 2'b01; wdata1 = 32'h12345678; req = 2'b10;
    push(2'b10, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("wr wmode", mem_write_mode, 2'b01);
    check("wr wbyte", mem_wbyte, 8'h78);
    check("wr addr", mem_address, 32'h40);
    repeat (2) begin
      @(negedge clk);
      check("wr wait ack", ack, 2'b00);
    end
    @(negedge clk);
    mem_done = 1'b1;
    wait_ack("wr", 4, n);
    mem_done = 1'b0; req = 2'b00;
    check("wr done latency", n, 1);
    check("wr recover wmode", mem_write_mode, 2'b00);
    check("wr recover busy", busy, 1'b1);
    @(negedge clk);
    check("wr idle busy", busy, 1'b0);
    check("wr ack pulse", ack, 2'b00);

    // Conflict: both ports held for four transactions
    addr0 = 32'h500; addr1 = 32'h600; wmode0 = 2'b00; wmode1 = 2'b00; req = 2'b11;
    for (int i = 0; i < 4; i++)
      push(exp_port[i] == 2'd1 ? 2'b10 : 2'b01, 1'b0, 1'b1,
           rd_model(exp_port[i] == 2'd1 ? 32'h600 : 32'h500));
    for (int i = 0; i < 4; i++) begin
      wait_ack("conflict", 10, n);
      check("conflict latency", n, 4);
    end
    req = 2'b00;
    @(negedge clk);
    check("conflict idle", busy, 1'b0);

    // Word write with error and done together
    addr0 = 32'h20000; wmode0 = 2'b11; wdata0 = 32'hCAFEF00D; req = 2'b01;
    push(2'b01, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check("err wword", mem_wword, 32'hCAFEF00D);
    check("err wmode", mem_write_mode, 2'b11);
    check("err addr", mem_address, 32'h20000);
    mem_error = 1'b1; mem_done = 1'b1;
    wait_ack("err", 4, n);
    mem_error = 1'b0; mem_done = 1'b0; req = 2'b00;
    check("err latency", n, 1);
    check("err wmode clr", mem_write_mode, 2'b00);
    @(negedge clk);
    check("err idle", busy, 1'b0);

    // Back-to-back: req0 held through ack, address changed for the second access
    addr0 = 32'h200; wmode0 = 2'b00; req = 2'b01;
    push(2'b01, 1'b0, 1'b1, rd_model(32'h200));
    wait_ack("b2b1", 8, n);
    check("b2b1 latency", n, 4);
    addr0 = 32'h300;
    push(2'b01, 1'b0, 1'b1, rd_model(32'h300));
    @(negedge clk);
    check("b2b regrant busy", busy, 1'b1);
    check("b2b relatch addr", mem_address, 32'h300);
    wait_ack("b2b2", 8, n);
    req = 2'b00;
    check("b2b2 latency", n, 3);
    @(negedge clk);
    check("b2b idle", busy, 1'b0);

    // Asynchronous reset in the middle of a half-word write
    addr1 = 32'h80; wmode1 = 2'b10; wdata1 = 32'hAABBCCDD; req = 2'b10;
    @(negedge clk);
    check("mid whalf", mem_whalf, 16'hCCDD);
    check("mid busy", busy, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid rst busy", busy, 1'b0);
    check("mid rst ack", ack, 2'b00);
    check("mid rst err", err, 1'b0);
    check("mid rst addr", mem_address, 32'h0);
    check("mid rst wmode", mem_write_mode, 2'b00);
    check("mid rst wword", mem_wword, 32'h0);
    check("mid rst rdata", rdata, 32'h0);
    req = 2'b00;
    @(negedge clk);
    rst = 1'b1; mem_done = 1'b1;
    @(negedge clk);
    mem_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("mid no ack", ack, 2'b00);
    end

    // After reset last_grant is port 1, so a conflict goes to port 0 in both builds
    addr0 = 32'h700; addr1 = 32'h800; wmode0 = 2'b00; wmode1 = 2'b00; req = 2'b11;
    push(2'b01, 1'b0, 1'b1, rd_model(32'h700));
    wait_ack("post rst conflict", 8, n);
    req = 2'b00;
    @(negedge clk);
    check("sb drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
